div_sequencer: RTL and testbench
================================

# div_sequencer

Multi-cycle sequencer for the M-extension divide/remainder datapath in the EX stage of the 5-stage pipeline. It latches operands when a DIV/DIVU/REM/REMU instruction enters EX, runs a 32-iteration radix-2 restoring division and applies RISC-V sign and special-case fix-ups. While the operation is in progress it drives the pipeline's `stall_div` hazard signal, freezing IF/ID/EX and bubbling MEM.

## Interface
Parameters:
- `XLEN`, 32, operand and result width; the iteration count equals `XLEN`.

Ports:
- `clk`  in  1  pipeline clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  EX holds a valid divide-class instruction; held high while stalled.
- `op`  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
- `rs1_data`  in  XLEN  dividend, forwarded.
- `rs2_data`  in  XLEN  divisor, forwarded.
- `flush`  in  1  branch flush; kills the EX instruction.
- `stall_div`  out  1  hazard stall request to the pipeline (combinational).
- `busy`  out  1  state is BUSY (registered).
- `done`  out  1  `result` valid this cycle (registered).
- `result`  out  XLEN  quotient or remainder (registered).

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE, `start`=1, `flush`=0:
  - Latch `op` and the operand magnitudes: abs value for DIV/REM, raw value for DIVU/REMU.
  - Record the quotient sign (signs differ) and the remainder sign (dividend sign).
  - Clear the partial remainder, load `count`=XLEN-1, then go to BUSY.
- BUSY, each cycle:
  - Shift {rem,quo} left by 1 and trial-subtract the divisor.
  - If there is no borrow, commit the difference and set quo[0]; otherwise keep the old value.
  - Decrement `count`. When `count`==0, this is the last iteration and the next state is DONE.
- BUSY→DONE: register `result` with the fix-ups below applied, and set `done`=1.
- DONE→IDLE unconditionally. `start` is still high in DONE because the same instruction is in EX; it must not restart.
- Fix-up rules:
  - Divisor 0: quotient 0xFFFFFFFF; remainder = original dividend.
  - DIV/REM with 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0.
  - Otherwise, for signed ops, negate the quotient if the signs differ and negate the remainder if the dividend is negative.
- `stall_div` = ~`flush` & ((IDLE & `start`) | BUSY).
- `flush` in any state: next state IDLE, `done` cleared next cycle, `result` holds its value, `stall_div` low in that cycle.
- If `start` and `flush` are both high in IDLE, no operation is launched.

## Timing
- Reset values:
  - State IDLE.
  - `count`=0.
  - `busy`=0, `done`=0, `result`=0.
  - `stall_div`=0 whenever `start`=0.
- Normal latency:
  - `start` is seen in IDLE at cycle 0.
  - BUSY occupies cycles 1..32.
  - DONE is cycle 33, with `done`=1, result valid and `stall_div`=0.
  - The instruction leaves EX at the end of cycle 33.
  - Total stall is 33 cycles.
- Back-to-back divides: the second `start` is seen in the IDLE cycle after DONE (cycle 34).
- Operands are sampled only in IDLE; changes on `rs1_data`/`rs2_data` during BUSY are ignored.
- Asynchronous `rst` mid-operation aborts immediately. All outputs return to their reset values without waiting for a clock edge.

## Configuration
- `DIV_FAST_PATH_EN` defined:
  - Divisor 0 and signed overflow skip BUSY and go IDLE→DONE directly with the fix-up result.
  - Latency is 1 cycle of stall, with `done` in cycle 1.
- Not defined:
  - Special cases run the full 32 iterations and the fix-up is applied at BUSY→DONE.
  - Results are identical; latency is 33 cycles.

## Test plan
- DIVU 100/7, then REMU 100/7 → `result`=14, then 2; `done` at cycle 33; `stall_div` high for cycles 0..32 exactly.
- DIV 0xFFFFFFF9 (-7) / 2 → 0xFFFFFFFD (-3); REM → 0xFFFFFFFF (-1); REMU same operands → 1.
- DIV 5/0 → 0xFFFFFFFF; REM 5/0 → 5; DIV 0x80000000/0xFFFFFFFF → 0x80000000, REM → 0. Latency is 1 cycle with `DIV_FAST_PATH_EN` and 33 without.
- DIVU 1000/10 with `flush` at cycle 10:
  - Next cycle: state IDLE, `busy`=0, `stall_div`=0, `done` never asserts.
  - A following DIVU 9/3 → 3 at its own cycle 33.
- `rst` asserted mid-BUSY between clock edges → `busy`, `done`, `result` and `stall_div` are 0 asynchronously.
- Back-to-back DIVU 50/5 then DIVU 81/9 → `done` with 10 at cycle 33, then with 9 at cycle 67; no spurious restart in either DONE cycle.

Source files
------------

// File: rtl/div_sequencer.sv
// Multi-cycle radix-2 restoring divide/remainder sequencer for the EX stage, with RISC-V sign and special-case fix-ups.
// Optional macro DIV_FAST_PATH_EN: divide-by-zero and signed overflow finish in one cycle instead of XLEN+1.
module div_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            flush,
    output logic            stall_div,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = (XLEN > 1) ? $clog2(XLEN) : 1;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state, state_nxt;

    logic [CW-1:0]   count;
    logic [XLEN-1:0] quo_q, rem_q, dvs_q, dvd_q;
    logic            is_rem_q, q_neg_q, r_neg_q, div0_q, ovf_q;

    // Operand decode, only meaningful while IDLE
    logic            sgn_in, a_neg, b_neg, div0_in, ovf_in, fast_in, launch;
    logic [XLEN-1:0] a_mag, b_mag;

    assign sgn_in  = ~op[0];
    assign a_neg   = sgn_in & rs1_data[XLEN-1];
    assign b_neg   = sgn_in & rs2_data[XLEN-1];
    assign a_mag   = a_neg ? -rs1_data : rs1_data;
    assign b_mag   = b_neg ? -rs2_data : rs2_data;
    assign div0_in = (rs2_data == '0);
    assign ovf_in  = sgn_in & (rs1_data == MIN_NEG) & (rs2_data == '1);
    assign launch  = (state == IDLE) & start & ~flush;
`ifdef DIV_FAST_PATH_EN
    assign fast_in = div0_in | ovf_in;
`else
    assign fast_in = 1'b0;
`endif

    // One restoring step: shift {rem,quo} left, trial-subtract divisor
    logic [XLEN:0]   shifted;
    logic [XLEN+1:0] trial;
    logic [XLEN-1:0] quo_nxt, rem_nxt;

    assign shifted = {rem_q, quo_q[XLEN-1]};
    assign trial   = {1'b0, shifted} - {2'b00, dvs_q};

    always_comb begin
        rem_nxt = shifted[XLEN-1:0];
        quo_nxt = {quo_q[XLEN-2:0], 1'b0};
        if (!trial[XLEN+1]) begin
            rem_nxt = trial[XLEN-1:0];
            quo_nxt = {quo_q[XLEN-2:0], 1'b1};
        end
    end

    function automatic logic [XLEN-1:0] fixup(
        input logic            is_rem, div0, ovf, q_neg, r_neg,
        input logic [XLEN-1:0] quo, rem, dvd
    );
        if (div0)   return is_rem ? dvd : '1;
        if (ovf)    return is_rem ? '0 : MIN_NEG;
        if (is_rem) return r_neg ? -rem : rem;
        return q_neg ? -quo : quo;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt == BUSY);
            done  <= (state_nxt == DONE);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start && !flush) state_nxt = fast_in ? DONE : BUSY;
            BUSY:    if (flush) state_nxt = IDLE;
                     else if (count == '0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Reset also drops the stall so the pipeline is released immediately
    always_comb begin
        stall_div = ~rst & ~flush & (((state == IDLE) & start) | (state == BUSY));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count    <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
            dvs_q    <= '0;
            dvd_q    <= '0;
            is_rem_q <= 1'b0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            div0_q   <= 1'b0;
            ovf_q    <= 1'b0;
            result   <= '0;
        end else begin
            if (launch) begin
                count    <= CW'(XLEN - 1);
                quo_q    <= a_mag;
                rem_q    <= '0;
                dvs_q    <= b_mag;
                dvd_q    <= rs1_data;
                is_rem_q <= op[1];
                q_neg_q  <= a_neg ^ b_neg;
                r_neg_q  <= a_neg;
                div0_q   <= div0_in;
                ovf_q    <= ovf_in;
                if (fast_in)
                    result <= fixup(op[1], div0_in, ovf_in, 1'b0, 1'b0, '0, '0, rs1_data);
            end else if (state == BUSY && !flush) begin
                quo_q <= quo_nxt;
                rem_q <= rem_nxt;
                if (count == '0)
                    result <= fixup(is_rem_q, div0_q, ovf_q, q_neg_q, r_neg_q,
                                    quo_nxt, rem_nxt, dvd_q);
                else
                    count <= count - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_div_sequencer.sv
// Scoreboard bench for div_sequencer: driver queues expected results/latency, negedge monitor checks on done.
module tb_div_sequencer;

    logic        clk = 1'b0, rst = 1'b1, start = 1'b0, flush = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [31:0] rs1_data = '0, rs2_data = '0;
    logic        stall_div, busy, done;
    logic [31:0] result;

    div_sequencer #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .rs1_data(rs1_data),
        .rs2_data(rs2_data), .flush(flush), .stall_div(stall_div), .busy(busy),
        .done(done), .result(result)
    );

    always #5 clk = ~clk;

`ifdef DIV_FAST_PATH_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a, b, res;
        int          lat;
        int          t0;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          n_vec = 0, n_err = 0, cyc = 0, stall_cnt = 0;
    logic [31:0] last_res = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_res(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic ovf;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (o)
            2'd0: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                return $signed(a) / $signed(b);
            end
            2'd1: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            2'd2: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                return $signed(a) % $signed(b);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        bit special;
        special = (b == 0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
        return (FAST && special) ? 1 : 33;
    endfunction

    always @(negedge clk) begin
        if (rst) stall_cnt = 0;
        else begin
            if (flush) stall_cnt = 0;
            else if (stall_div) stall_cnt++;
            if (done) begin
                if (sb.size() == 0) check("spurious_done", {31'b0, done}, 32'd0);
                else begin
                    mon_e = sb.pop_front();
                    check($sformatf("result op%0d %h/%h", mon_e.op, mon_e.a, mon_e.b), result, mon_e.res);
                    check("latency", cyc - mon_e.t0, mon_e.lat);
                    check("stall_cycles", stall_cnt, mon_e.lat);
                    check("stall_in_done", {31'b0, stall_div}, 32'd0);
                    stall_cnt = 0;
                end
            end
        end
    end

    task automatic finish_run();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    endtask

    // Issue one instruction; start stays high through its DONE cycle, operands scrambled meanwhile
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        @(posedge clk); #1;
        start = 1'b1; op = o; rs1_data = a; rs2_data = b;
        e.op = o; e.a = a; e.b = b; e.res = ref_res(o, a, b); e.lat = ref_lat(o, a, b); e.t0 = cyc;
        sb.push_back(e);
        last_res = e.res;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (done) return;
            rs1_data = $urandom; rs2_data = $urandom;
        end
        n_vec++; n_err++;
        $display("FAIL timeout: no done for op%0d %h/%h", o, a, b);
        finish_run();
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
    endtask

    initial begin
        logic [1:0]  o;
        logic [31:0] a, b;
        repeat (2) @(negedge clk);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_stall", {31'b0, stall_div}, 32'd0);
        @(posedge clk); #1; rst = 1'b0;

        run_op(2'd1, 32'd100, 32'd7); idle(2);
        run_op(2'd3, 32'd100, 32'd7); idle(1);
        run_op(2'd0, 32'hFFFF_FFF9, 32'd2);
        run_op(2'd2, 32'hFFFF_FFF9, 32'd2);
        run_op(2'd3, 32'hFFFF_FFF9, 32'd2); idle(1);
        run_op(2'd0, 32'd5, 32'd0);
        run_op(2'd2, 32'd5, 32'd0);
        run_op(2'd0, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF); idle(1);
        run_op(2'd1, 32'd77, 32'd0); idle(1);

        // Flush at cycle 10 of a DIVU: killed, nothing reported
        @(posedge clk); #1;
        start = 1'b1; op = 2'd1; rs1_data = 32'd1000; rs2_data = 32'd10;
        repeat (10) @(posedge clk);
        #1; flush = 1'b1;
        #1; check("flush_stall", {31'b0, stall_div}, 32'd0);
        @(posedge clk); #1;
        flush = 1'b0; start = 1'b0;
        check("flush_busy", {31'b0, busy}, 32'd0);
        check("flush_stall_after", {31'b0, stall_div}, 32'd0);
        check("flush_done", {31'b0, done}, 32'd0);
        check("flush_result_hold", result, last_res);
        idle(3);
        run_op(2'd1, 32'd9, 32'd3); idle(1);

        // Async reset between edges while BUSY, start still high
        @(posedge clk); #1;
        start = 1'b1; op = 2'd0; rs1_data = 32'd12345; rs2_data = 32'd7;
        repeat (5) @(posedge clk);
        #3; rst = 1'b1;
        #1;
        check("arst_busy", {31'b0, busy}, 32'd0);
        check("arst_done", {31'b0, done}, 32'd0);
        check("arst_result", result, 32'd0);
        check("arst_stall", {31'b0, stall_div}, 32'd0);
        @(posedge clk); #1;
        start = 1'b0; rst = 1'b0;
        idle(1);

        run_op(2'd1, 32'd50, 32'd5);
        run_op(2'd1, 32'd81, 32'd9); idle(2);

        for (int i = 0; i < 40; i++) begin
            o = 2'($urandom_range(0, 3));
            a = $urandom; b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: begin a = 32'($urandom_range(0, 300)); b = 32'($urandom_range(1, 20)); end
                3: b = 32'(0 - $urandom_range(1, 20));
                default: ;
            endcase
            run_op(o, a, b);
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
        end
        idle(3);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        finish_run();
    end

endmodule
